// File: rtl/seq_trigger.sv
// Multi-stage sequential trigger: each stage must see its channel/protocol
// condition a programmed number of times before the next stage is evaluated.
module seq_trigger #(
   parameter  int NUM_CH     = 5,
   parameter  int NUM_STAGES = 2,
   parameter  int CNT_W      = 8,
   localparam int SW         = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           armed,
   input  logic [NUM_CH-1:0]              chH,
   input  logic [NUM_CH-1:0]              chL,
   input  logic [NUM_STAGES*NUM_CH*5-1:0] stage_cfg,
   input  logic [NUM_STAGES*CNT_W-1:0]    stage_cnt,
   input  logic [NUM_STAGES-1:0]          stage_prot_en,
   input  logic                           protTrig,
   input  logic                           set_capture_done,
   output logic                           triggered,
   output logic [SW-1:0]                  cur_stage,
   output logic [CNT_W-1:0]               hit_cnt
);

   // Stage tables are padded to a power of two so cur_stage indexes them directly.
   localparam int NS_P = 1 << SW;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_TRIGD = 2'd2
   } state_e;

   state_e               state_q, state_d;
   logic [SW-1:0]        stage_q, stage_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 trig_q, trig_d;
   logic [NUM_CH-1:0]    chh_prev_q;
   logic [NUM_CH-1:0]    chl_prev_q;

   logic [NUM_CH-1:0]    rise_s;
   logic [NUM_CH-1:0]    fall_s;
   logic [NUM_CH*5-1:0]  cfg_tab_s [NS_P];
   logic [CNT_W-1:0]     tgt_tab_s [NS_P];
   logic [NS_P-1:0]      prot_tab_s;
   logic [NUM_CH*5-1:0]  cfg_cur_s;
   logic [CNT_W-1:0]     tgt_raw_s;
   logic [CNT_W-1:0]     tgt_eff_s;
   logic [NUM_CH-1:0]    ch_ok_s;
   logic                 stage_hit_s;
   logic                 reach_s;
   logic                 last_s;

   function automatic logic ch_ok(input logic [4:0] cfg, input logic rise,
                                  input logic fall, input logic hi, input logic lo);
      return cfg[0] | (cfg[4] & rise) | (cfg[3] & fall) | (cfg[2] & hi) | (cfg[1] & ~lo);
   endfunction

   assign rise_s = chH & ~chh_prev_q;
   assign fall_s = ~chL & chl_prev_q;

   // Unused padding stages get an all-zero config, which can never be satisfied.
   for (genvar s = 0; s < NS_P; s++) begin : g_stage
      if (s < NUM_STAGES) begin : g_real
         assign cfg_tab_s[s]  = stage_cfg[s*NUM_CH*5 +: NUM_CH*5];
         assign tgt_tab_s[s]  = stage_cnt[s*CNT_W +: CNT_W];
         assign prot_tab_s[s] = stage_prot_en[s];
      end else begin : g_pad
         assign cfg_tab_s[s]  = '0;
         assign tgt_tab_s[s]  = '0;
         assign prot_tab_s[s] = 1'b0;
      end
   end

   assign cfg_cur_s = cfg_tab_s[stage_q];
   assign tgt_raw_s = tgt_tab_s[stage_q];

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      assign ch_ok_s[c] = ch_ok(cfg_cur_s[c*5 +: 5], rise_s[c], fall_s[c], chH[c], chL[c]);
   end

   assign stage_hit_s = (&ch_ok_s) & (~prot_tab_s[stage_q] | protTrig);
   assign tgt_eff_s   = (tgt_raw_s == '0) ? CNT_W'(1) : tgt_raw_s;
   // One bit wider so a full-scale count plus one cannot wrap below the target.
   assign reach_s     = (({1'b0, cnt_q} + (CNT_W+1)'(1)) >= {1'b0, tgt_eff_s});
   assign last_s      = (stage_q == SW'(NUM_STAGES - 1));

   // State and counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         stage_q <= '0;
         cnt_q   <= '0;
         trig_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         stage_q <= stage_d;
         cnt_q   <= cnt_d;
         trig_q  <= trig_d;
      end
   end

   // Edge history tracks the inputs every cycle, independent of the FSM.
   always_ff @(posedge clk) begin
      if (rst) begin
         chh_prev_q <= '1;
         chl_prev_q <= '0;
      end else begin
         chh_prev_q <= chH;
         chl_prev_q <= chL;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      if (set_capture_done) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (armed) state_d = ST_RUN;
               else       state_d = ST_IDLE;
            end
            ST_RUN: begin
               if (!armed)                              state_d = ST_IDLE;
               else if (stage_hit_s && reach_s && last_s) state_d = ST_TRIGD;
               else                                     state_d = ST_RUN;
            end
            ST_TRIGD: state_d = ST_TRIGD;
            default:  state_d = ST_IDLE;
         endcase
      end
   end

   // Stage/count/trigger updates; capture-done overrides a coincident final hit.
   always_comb begin
      stage_d = stage_q;
      cnt_d   = cnt_q;
      trig_d  = trig_q;
      if (set_capture_done) begin
         stage_d = '0;
         cnt_d   = '0;
         trig_d  = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               stage_d = '0;
               cnt_d   = '0;
               trig_d  = 1'b0;
            end
            ST_RUN: begin
               if (!armed) begin
                  stage_d = '0;
                  cnt_d   = '0;
                  trig_d  = 1'b0;
               end else if (stage_hit_s) begin
                  if (reach_s) begin
                     if (last_s) begin
                        trig_d = 1'b1;
                     end else begin
                        stage_d = stage_q + SW'(1);
                        cnt_d   = '0;
                     end
                  end else begin
                     cnt_d = cnt_q + CNT_W'(1);
                  end
               end else begin
                  cnt_d = cnt_q;
               end
            end
            ST_TRIGD: trig_d = 1'b1;
            default: begin
               stage_d = '0;
               cnt_d   = '0;
               trig_d  = 1'b0;
            end
         endcase
      end
   end

   // Outputs come straight from registers.
   always_comb begin
      triggered = trig_q;
      cur_stage = stage_q;
      hit_cnt   = cnt_q;
   end

endmodule

// File: tb/tb_seq_trigger.sv
// Directed bench for seq_trigger with default parameters (5 channels, 2 stages).
module tb_seq_trigger;

   localparam int NUM_CH     = 5;
   localparam int NUM_STAGES = 2;
   localparam int CNT_W      = 8;
   localparam int SW         = 1;

   localparam logic [4:0] C_RISE = 5'b10000;
   localparam logic [4:0] C_FALL = 5'b01000;
   localparam logic [4:0] C_HIGH = 5'b00100;
   localparam logic [4:0] C_LOW  = 5'b00010;
   localparam logic [4:0] C_DC   = 5'b00001;

   logic                           clk = 1'b0;
   logic                           rst;
   logic                           armed;
   logic [NUM_CH-1:0]              chH;
   logic [NUM_CH-1:0]              chL;
   logic [NUM_STAGES*NUM_CH*5-1:0] stage_cfg;
   logic [NUM_STAGES*CNT_W-1:0]    stage_cnt;
   logic [NUM_STAGES-1:0]          stage_prot_en;
   logic                           protTrig;
   logic                           set_capture_done;
   logic                           triggered;
   logic [SW-1:0]                  cur_stage;
   logic [CNT_W-1:0]               hit_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   seq_trigger #(.NUM_CH(NUM_CH), .NUM_STAGES(NUM_STAGES), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .armed(armed), .chH(chH), .chL(chL),
      .stage_cfg(stage_cfg), .stage_cnt(stage_cnt), .stage_prot_en(stage_prot_en),
      .protTrig(protTrig), .set_capture_done(set_capture_done),
      .triggered(triggered), .cur_stage(cur_stage), .hit_cnt(hit_cnt)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic set_cfg(input int s, input int c, input logic [4:0] v);
      stage_cfg[(s*NUM_CH + c)*5 +: 5] = v;
   endtask

   task automatic all_dc();
      for (int s = 0; s < NUM_STAGES; s++)
         for (int c = 0; c < NUM_CH; c++)
            set_cfg(s, c, C_DC);
   endtask

   task automatic set_cnt(input int s, input logic [CNT_W-1:0] v);
      stage_cnt[s*CNT_W +: CNT_W] = v;
   endtask

   task automatic capture_done();
      set_capture_done = 1'b1;
      armed            = 1'b0;
      tick();
      set_capture_done = 1'b0;
   endtask

   initial begin
      rst = 1'b1; armed = 1'b0; chH = 5'b00000; chL = 5'b11111;
      stage_cfg = '0; stage_cnt = '0; stage_prot_en = 2'b00;
      protTrig = 1'b0; set_capture_done = 1'b0;
      tick(2);
      rst = 1'b0;
      check_eq("rst_trig",  32'(triggered), 32'd0);
      check_eq("rst_stage", 32'(cur_stage), 32'd0);
      check_eq("rst_cnt",   32'(hit_cnt),   32'd0);

      // Rise on CH1 in the final stage; stage 0 is don't-care.
      all_dc(); set_cnt(0, 8'd1); set_cnt(1, 8'd1);
      set_cfg(1, 0, C_RISE);
      armed = 1'b1;
      tick();                       // IDLE -> RUN
      tick();                       // stage 0 satisfied
      check_eq("rise_adv", 32'(cur_stage), 32'd1);
      tick(3);
      check_eq("rise_wait", 32'(triggered), 32'd0);
      chH[0] = 1'b1;
      tick();
      check_eq("rise_trig", 32'(triggered), 32'd1);
      armed = 1'b0; chH[0] = 1'b0;
      tick(); chH[0] = 1'b1; tick(2);
      check_eq("rise_hold", 32'(triggered), 32'd1);
      check_eq("rise_frz",  32'(cur_stage), 32'd1);
      capture_done();
      check_eq("rise_done", 32'(triggered), 32'd0);
      check_eq("rise_idle", 32'(cur_stage), 32'd0);

      // Stage 0: three CH2 falls; stage 1: CH3 high, already true.
      all_dc(); set_cfg(0, 1, C_FALL); set_cfg(1, 2, C_HIGH);
      set_cnt(0, 8'd3); set_cnt(1, 8'd1);
      chH = 5'b00100; chL = 5'b11111; armed = 1'b1;
      tick();
      chL[1] = 1'b0; tick();
      check_eq("fall_cnt1", 32'(hit_cnt), 32'd1);
      chL[1] = 1'b1; tick();
      check_eq("fall_nohit", 32'(hit_cnt), 32'd1);
      chL[1] = 1'b0; tick();
      chL[1] = 1'b1; tick();
      chL[1] = 1'b0; tick();
      check_eq("fall_adv",  32'(cur_stage), 32'd1);
      check_eq("fall_clr",  32'(hit_cnt),   32'd0);
      check_eq("fall_same", 32'(triggered), 32'd0);
      chL[1] = 1'b1; tick();
      check_eq("fall_trig", 32'(triggered), 32'd1);
      capture_done();

      // Level counting: CH1 low, four occurrences.
      all_dc(); set_cfg(0, 0, C_LOW); set_cnt(0, 8'd4); set_cnt(1, 8'd1);
      chH = 5'b00000; chL = 5'b11111; armed = 1'b1;
      tick();
      chL[0] = 1'b0; tick(3);
      check_eq("lvl_cnt3", 32'(hit_cnt), 32'd3);
      chL[0] = 1'b1; tick(2);
      check_eq("lvl_keep",  32'(hit_cnt),   32'd3);
      check_eq("lvl_noadv", 32'(cur_stage), 32'd0);
      chL[0] = 1'b0; tick();
      check_eq("lvl_adv", 32'(cur_stage), 32'd1);
      chL[0] = 1'b1; tick();
      check_eq("lvl_trig", 32'(triggered), 32'd1);
      capture_done();

      // Abort mid-stage and restart.
      armed = 1'b1; tick();
      chL[0] = 1'b0; tick(2);
      check_eq("abort_pre", 32'(hit_cnt), 32'd2);
      armed = 1'b0; chL[0] = 1'b1; tick();
      check_eq("abort_clr", 32'(hit_cnt), 32'd0);
      armed = 1'b1; tick();
      check_eq("rearm_zero", 32'(hit_cnt), 32'd0);
      chL[0] = 1'b0; tick();
      check_eq("rearm_cnt1", 32'(hit_cnt), 32'd1);
      armed = 1'b0; chL[0] = 1'b1; tick();

      // Protocol-qualified stages, channels don't-care.
      all_dc(); set_cnt(0, 8'd1); set_cnt(1, 8'd1); stage_prot_en = 2'b11;
      armed = 1'b1; tick(3);
      check_eq("prot_wait", 32'(cur_stage), 32'd0);
      protTrig = 1'b1; tick();
      check_eq("prot_adv", 32'(cur_stage), 32'd1);
      protTrig = 1'b0; tick();
      check_eq("prot_notrig", 32'(triggered), 32'd0);
      protTrig = 1'b1; tick();
      check_eq("prot_trig", 32'(triggered), 32'd1);
      protTrig = 1'b0;
      capture_done();

      // No protocol qualification, target 0 treated as 1.
      stage_prot_en = 2'b00; set_cnt(0, 8'd0); set_cnt(1, 8'd0);
      armed = 1'b1; tick();
      check_eq("dc_run", 32'(triggered), 32'd0);
      tick();
      check_eq("dc_adv", 32'(cur_stage), 32'd1);
      tick();
      check_eq("dc_trig", 32'(triggered), 32'd1);
      capture_done();

      // Capture-done coincident with the final hit.
      armed = 1'b1; tick(2);
      set_capture_done = 1'b1; tick();
      set_capture_done = 1'b0;
      check_eq("coin_trig",  32'(triggered), 32'd0);
      check_eq("coin_stage", 32'(cur_stage), 32'd0);
      check_eq("coin_cnt",   32'(hit_cnt),   32'd0);
      armed = 1'b0; tick();
      check_eq("coin_idle", 32'(triggered), 32'd0);

      // Reset mid-run, then a steady-high channel must not look like a rise.
      all_dc(); set_cfg(0, 0, C_HIGH); set_cnt(0, 8'd5); set_cnt(1, 8'd1);
      chH = 5'b11111; armed = 1'b1; tick();
      tick(2);
      check_eq("rstrun_cnt", 32'(hit_cnt), 32'd2);
      rst = 1'b1; tick();
      check_eq("rstrun_clr", 32'(hit_cnt), 32'd0);
      rst = 1'b0;
      set_cfg(0, 0, C_RISE);
      tick(3);
      check_eq("norise_stage", 32'(cur_stage), 32'd0);
      check_eq("norise_trig",  32'(triggered), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
